icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache placed between the fetch-stage PC and the backing instruction memory.
- Supplies a 32-bit instruction to the IF/ID register on a hit.
- On a miss, stalls the pipeline and refills the line one word per beat over a simple request/valid memory interface.
- Keeps a saturating miss counter for performance checks.

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_line_store.sv | 57 +++++
 rtl/icache_direct.sv | 166 ++++++++++++++++
 tb/tb_icache_direct.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// the instruction/address width and the address-field width helpers.
package icache_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } cacheState_t;

    function automatic int offsetWidth(input int words);
        return $clog2(words);
    endfunction

    function automatic int indexWidth(input int lines);
        return $clog2(lines);
    endfunction

    // Two low address bits select a byte within the word and are dropped.
    function automatic int tagWidth(input int lines, input int words);
        return XLEN - 2 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Flop-based data, tag and valid storage for the instruction cache with a
// combinational read port and separate word and tag/valid write ports.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int OFF_W = offsetWidth(WORDS),
    parameter int IDX_W = indexWidth(LINES),
    parameter int TAG_W = tagWidth(LINES, WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clearAll,
    input  logic             wordWe,
    input  logic [IDX_W-1:0] wrIndex,
    input  logic [OFF_W-1:0] wrOffset,
    input  logic [XLEN-1:0]  wrData,
    input  logic             tagWe,
    input  logic [TAG_W-1:0] wrTag,
    input  logic             wrValid,
    input  logic [IDX_W-1:0] rdIndex,
    input  logic [OFF_W-1:0] rdOffset,
    output logic [XLEN-1:0]  rdWord,
    output logic [TAG_W-1:0] rdTag,
    output logic             rdValid
);

    logic [XLEN-1:0]  dataArr [LINES][WORDS];
    logic [TAG_W-1:0] tagArr  [LINES];
    logic [LINES-1:0] validArr;

    // Data and tags are never reset; the valid bits alone decide a hit.
    always_ff @(posedge clk) begin
        if (wordWe) begin
            dataArr[wrIndex][wrOffset] <= wrData;
        end
        if (tagWe) begin
            tagArr[wrIndex] <= wrTag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validArr <= '0;
        end else if (clearAll) begin
            validArr <= '0;
        end else if (tagWe) begin
            validArr[wrIndex] <= wrValid;
        end
    end

    assign rdWord  = dataArr[rdIndex][rdOffset];
    assign rdTag   = tagArr[rdIndex];
    assign rdValid = validArr[rdIndex];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: single-cycle hits, stalling
// line refill over a request/valid memory port, saturating miss counter.
module icache_direct
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic [XLEN-1:0]  cpu_addr,
    input  logic             flush,
    output logic [XLEN-1:0]  cpu_inst,
    output logic             cpu_valid,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [CNT_W-1:0] miss_count
);

    localparam int OFF_W = offsetWidth(WORDS);
    localparam int IDX_W = indexWidth(LINES);
    localparam int TAG_W = tagWidth(LINES, WORDS);

    cacheState_t      state, stateNext;
    logic [TAG_W-1:0] cpuTag, latTag, rdTag;
    logic [IDX_W-1:0] cpuIndex, latIndex, rdIndex;
    logic [OFF_W-1:0] cpuOffset, latOffset, rdOffset, beat;
    logic [XLEN-1:0]  rdWord;
    logic             rdValid, hit, missStart, lastBeat;
    logic             wordWe, tagWe, clearAll, flushPending;
    logic             unusedAddrBits;

    assign cpuOffset      = cpu_addr[2 +: OFF_W];
    assign cpuIndex       = cpu_addr[2 + OFF_W +: IDX_W];
    assign cpuTag         = cpu_addr[XLEN-1 -: TAG_W];
    assign unusedAddrBits = ^cpu_addr[1:0];

    // IDLE looks up the live fetch address; later states read the latched miss.
    assign rdIndex  = (state == IDLE) ? cpuIndex  : latIndex;
    assign rdOffset = (state == IDLE) ? cpuOffset : latOffset;

    icache_line_store #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) lineStore (
        .clk      (clk),
        .reset    (reset),
        .clearAll (clearAll),
        .wordWe   (wordWe),
        .wrIndex  (latIndex),
        .wrOffset (beat),
        .wrData   (mem_rdata),
        .tagWe    (tagWe),
        .wrTag    (latTag),
        .wrValid  (!(flushPending || flush)),
        .rdIndex  (rdIndex),
        .rdOffset (rdOffset),
        .rdWord   (rdWord),
        .rdTag    (rdTag),
        .rdValid  (rdValid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A flush in IDLE clears the array first, so a same-cycle fetch misses.
    always_comb begin
        stateNext = state;
        wordWe    = 1'b0;
        tagWe     = 1'b0;
        clearAll  = 1'b0;
        missStart = 1'b0;
        lastBeat  = (beat == OFF_W'(WORDS - 1));
        hit       = rdValid && (rdTag == cpuTag) && !flush;
        case (state)
            IDLE: begin
                clearAll = flush;
                if (cpu_req && !hit) begin
                    missStart = 1'b1;
                    stateNext = REFILL;
                end
            end
            REFILL: begin
                if (mem_rvalid) begin
                    wordWe = 1'b1;
                    if (lastBeat) begin
                        tagWe     = 1'b1;
                        stateNext = RESPOND;
                    end
                end
            end
            RESPOND: begin
                clearAll  = flushPending || flush;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_inst     <= '0;
            cpu_valid    <= 1'b0;
            cpu_stall    <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            miss_count   <= '0;
            beat         <= '0;
            latTag       <= '0;
            latIndex     <= '0;
            latOffset    <= '0;
            flushPending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_valid <= 1'b0;
                    if (cpu_req && hit) begin
                        cpu_valid <= 1'b1;
                        cpu_inst  <= rdWord;
                    end else if (missStart) begin
                        latTag    <= cpuTag;
                        latIndex  <= cpuIndex;
                        latOffset <= cpuOffset;
                        cpu_stall <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_addr  <= {cpuTag, cpuIndex, {OFF_W{1'b0}}, 2'b00};
                        beat      <= '0;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + CNT_W'(1);
                        end
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flushPending <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        beat     <= beat + OFF_W'(1);
                        mem_addr <= mem_addr + 32'd4;
                        if (lastBeat) begin
                            mem_req <= 1'b0;
                        end
                    end
                end
                RESPOND: begin
                    cpu_valid    <= 1'b1;
                    cpu_inst     <= rdWord;
                    cpu_stall    <= 1'b0;
                    flushPending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct; memory returns the
// bitwise inverse of each word address so every refilled word is distinct.
module tb_icache_direct;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        flush;
    logic [31:0] cpu_inst;
    logic        cpu_valid;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [15:0] miss_count;

    int testsRun;
    int testsFailed;

    icache_direct dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .flush      (flush),
        .cpu_inst   (cpu_inst),
        .cpu_valid  (cpu_valid),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .miss_count (miss_count)
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return ~addr;
    endfunction

    assign mem_rdata = memWord(mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One fetch from request to cpu_valid; inputs change on negedges only.
    task automatic doFetch(input logic [31:0] addr, input int gap, input int flushCyc,
                           output logic [31:0] inst, output int stalls, output int latency,
                           output int beats, output bit addrOk, output bit timedOut);
        int waitLeft;
        logic [31:0] base;
        base = {addr[31:4], 4'h0};
        stalls = 0; latency = 0; beats = 0; addrOk = 1'b1; timedOut = 1'b1;
        inst = '0; waitLeft = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; mem_rvalid = 1'b0; flush = (flushCyc == 0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            flush = (cyc == flushCyc);
            mem_rvalid = 1'b0;
            if (cpu_valid) begin
                inst = cpu_inst; latency = cyc; timedOut = 1'b0;
                cpu_req = 1'b0; flush = 1'b0;
                break;
            end
            if (cpu_stall) stalls++;
            if (mem_req) begin
                if (mem_addr !== base + 32'(beats * 4)) addrOk = 1'b0;
                if (waitLeft > 0) begin
                    waitLeft--;
                end else begin
                    mem_rvalid = 1'b1; beats++; waitLeft = gap;
                end
            end
        end
        cpu_req = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (cpu_inst !== 32'h0 || cpu_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_cpu: inst=%h valid=%b stall=%b expected 0/0/0", cpu_inst, cpu_valid, cpu_stall);
        end
        testsRun++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || miss_count !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mem: req=%b addr=%h misses=%0d expected 0/0/0", mem_req, mem_addr, miss_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_cold_miss;
        logic [31:0] inst; int stalls, latency, beats; bit addrOk, timedOut;
        doFetch(32'h40, 0, -1, inst, stalls, latency, beats, addrOk, timedOut);
        testsRun++;
        if (timedOut || inst !== memWord(32'h40)) begin
            testsFailed++;
            $display("[TB] FAIL cold_inst: got %h expected %h timeout=%b", inst, memWord(32'h40), timedOut);
        end
        testsRun++;
        if (stalls != 5 || latency != 6) begin
            testsFailed++;
            $display("[TB] FAIL cold_timing: stall=%0d latency=%0d expected 5/6", stalls, latency);
        end
        testsRun++;
        if (beats != 4 || !addrOk) begin
            testsFailed++;
            $display("[TB] FAIL cold_addr: beats=%0d addrOk=%b expected 4/1", beats, addrOk);
        end
        testsRun++;
        if (miss_count !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL cold_count: got %0d expected 1", miss_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [2];
        addrs[0] = 32'h44; addrs[1] = 32'h48;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addrs[0];
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            testsRun++;
            if (cpu_valid !== 1'b1 || cpu_inst !== memWord(addrs[i]) || mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL hit_%0d: valid=%b inst=%h req=%b stall=%b expected 1/%h/0/0",
                         i, cpu_valid, cpu_inst, mem_req, cpu_stall, memWord(addrs[i]));
            end
            if (i == 0) cpu_addr = addrs[1];
            else cpu_req = 1'b0;
        end
        @(negedge clk);
        testsRun++;
        if (cpu_valid !== 1'b0 || miss_count !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL hit_idle: valid=%b misses=%0d expected 0/1", cpu_valid, miss_count);
        end
    endtask

    task automatic test_conflict;
        logic [31:0] addrs [3];
        int expBeats [3];
        logic [31:0] inst; int stalls, latency, beats; bit addrOk, timedOut;
        addrs[0] = 32'h40; addrs[1] = 32'h140; addrs[2] = 32'h40;
        expBeats[0] = 0; expBeats[1] = 4; expBeats[2] = 4;
        for (int i = 0; i < 3; i++) begin
            doFetch(addrs[i], 0, -1, inst, stalls, latency, beats, addrOk, timedOut);
            testsRun++;
            if (timedOut || inst !== memWord(addrs[i]) || beats != expBeats[i] || !addrOk) begin
                testsFailed++;
                $display("[TB] FAIL conflict_%0d: inst=%h beats=%0d addrOk=%b expected %h/%0d/1",
                         i, inst, beats, addrOk, memWord(addrs[i]), expBeats[i]);
            end
        end
        testsRun++;
        if (miss_count !== 16'd3) begin
            testsFailed++;
            $display("[TB] FAIL conflict_count: got %0d expected 3", miss_count);
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] inst; int stalls, latency, beats; bit addrOk, timedOut;
        doFetch(32'h208, 2, -1, inst, stalls, latency, beats, addrOk, timedOut);
        testsRun++;
        if (timedOut || inst !== memWord(32'h208)) begin
            testsFailed++;
            $display("[TB] FAIL wait_inst: got %h expected %h", inst, memWord(32'h208));
        end
        testsRun++;
        if (stalls != 11 || latency != 12 || !addrOk || beats != 4) begin
            testsFailed++;
            $display("[TB] FAIL wait_timing: stall=%0d latency=%0d addrOk=%b beats=%0d expected 11/12/1/4",
                     stalls, latency, addrOk, beats);
        end
    endtask

    task automatic test_flush;
        logic [31:0] inst; int stalls, latency, beats; bit addrOk, timedOut;
        doFetch(32'h80, 0, 2, inst, stalls, latency, beats, addrOk, timedOut);
        testsRun++;
        if (timedOut || inst !== memWord(32'h80) || latency != 6) begin
            testsFailed++;
            $display("[TB] FAIL flush_resp: inst=%h latency=%0d expected %h/6", inst, latency, memWord(32'h80));
        end
        doFetch(32'h80, 0, -1, inst, stalls, latency, beats, addrOk, timedOut);
        testsRun++;
        if (timedOut || beats != 4 || inst !== memWord(32'h80) || miss_count !== 16'd6) begin
            testsFailed++;
            $display("[TB] FAIL flush_refetch: beats=%0d inst=%h misses=%0d expected 4/%h/6",
                     beats, inst, miss_count, memWord(32'h80));
        end
        doFetch(32'h84, 0, 0, inst, stalls, latency, beats, addrOk, timedOut);
        testsRun++;
        if (timedOut || beats != 4 || inst !== memWord(32'h84) || miss_count !== 16'd7) begin
            testsFailed++;
            $display("[TB] FAIL flush_idle: beats=%0d inst=%h misses=%0d expected 4/%h/7",
                     beats, inst, miss_count, memWord(32'h84));
        end
        doFetch(32'h8C, 0, -1, inst, stalls, latency, beats, addrOk, timedOut);
        testsRun++;
        if (timedOut || latency != 1 || beats != 0 || inst !== memWord(32'h8C)) begin
            testsFailed++;
            $display("[TB] FAIL flush_hit: latency=%0d beats=%0d inst=%h expected 1/0/%h",
                     latency, beats, inst, memWord(32'h8C));
        end
    endtask

    task automatic test_reset_mid_refill;
        logic [31:0] inst; int stalls, latency, beats; bit addrOk, timedOut;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h300;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_valid !== 1'b0 || miss_count !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_drop: req=%b stall=%b valid=%b misses=%0d expected 0/0/0/0",
                     mem_req, cpu_stall, cpu_valid, miss_count);
        end
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if (mem_req !== 1'b0 || cpu_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_idle: req=%b valid=%b stall=%b expected 0/0/0", mem_req, cpu_valid, cpu_stall);
        end
        mem_rvalid = 1'b0;
        doFetch(32'h300, 0, -1, inst, stalls, latency, beats, addrOk, timedOut);
        testsRun++;
        if (timedOut || beats != 4 || inst !== memWord(32'h300) || miss_count !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL midreset_refetch: beats=%0d inst=%h misses=%0d expected 4/%h/1",
                     beats, inst, miss_count, memWord(32'h300));
        end
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0; mem_rvalid = 1'b0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_wait_states();
        test_flush();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
